mmd_divider_ctrl: RTL and testbench
===================================

Name: mmd_divider_ctrl

Overview:
Programmable multi-modulus divider stage that sits directly downstream of the MASH modulator in the fractional-N divider. It adds the signed MASH offset to the integer divide ratio, clamps the result, and counts input clock cycles to produce the divided output. Each period it emits a one-cycle strobe, which clocks or enables the MASH to fetch its next sample. The average divide ratio is therefore n_int + frac/modulus.

Parameters:
WIDTH_N, 8, width of the integer ratio and the down-counter.
ORDER, 3, MASH order; mash_in is an ORDER-bit two's-complement value.
N_MIN, 4, minimum legal divide ratio; must be >= 3.

Ports:
clk  in  1  divider input clock (VCO/prescaler domain); the only clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable; when low, all state holds.
n_int  in  WIDTH_N  unsigned integer divide ratio.
mash_in  in  ORDER  signed MASH offset; sign-extended before use.
div_out  out  1  divided clock, approx. 50% duty.
div_pulse  out  1  one-cycle pulse at the start of each period.
mash_strobe  out  1  identical to div_pulse; advances the MASH.
ratio_cur  out  WIDTH_N  ratio of the period in progress (debug).
clamp_flag  out  1  high while the period in progress uses a clamped ratio.

Behaviour:
- All state is in flops with async reset. There are no combinational paths from inputs to outputs.
- Ratio calculation:
  - r_calc = n_int + sext(mash_in), computed signed at WIDTH_N+2 bits.
  - If r_calc < N_MIN, use N_MIN; if r_calc > 2^WIDTH_N-1, use 2^WIDTH_N-1; otherwise use r_calc.
  - A clamp bit is produced alongside the result.
- Sample point:
  - On the edge where count==1 and en=1, ratio_pend and clamp_pend capture the clamped ratio and clamp bit.
  - n_int and mash_in are ignored at all other times.
  - The MASH value presented after strobe k sets the length of period k+1.
  - Because N_MIN >= 3, the MASH has at least 2 cycles to settle before the sample point.
- Counter:
  - count decrements by 1 per enabled cycle.
  - On an enabled edge with count==0 (terminal count): count <= ratio_pend-1, ratio_cur <= ratio_pend, clamp_flag <= clamp_pend, div_pulse <= 1.
  - On every other edge, div_pulse <= 0.
  - div_pulse is high for exactly one cycle per period; the period length equals ratio_cur cycles.
- div_out:
  - Registered from the next count value.
  - High while count >= ratio_cur>>1, giving ceil(R/2) cycles high and floor(R/2) cycles low.
  - Goes high on the same edge that div_pulse rises.
- en low: count, ratio registers and div_out hold, and div_pulse is forced to 0. Counting resumes seamlessly when en returns high.
- Reset values (applied immediately on rst, also mid-period):
  - count = N_MIN-1
  - ratio_cur = ratio_pend = N_MIN
  - clamp_flag = clamp_pend = 0
  - div_out = 0, div_pulse = 0
- Startup after reset:
  - The first period has length N_MIN.
  - The first div_pulse is asserted on the N_MIN-th enabled edge after reset deassert.
  - The first high phase may be shortened by one cycle; this is accepted behaviour.
- Mid-period changes: changing n_int mid-period has no effect until the next sample point. There is no glitching of the current period.

Decomposition:
- Shared package/header frac_div_pkg holds the N_MIN default, WIDTH_N/ORDER defaults, and a sign-extension width constant (WIDTH_N+2).
- One sub-module, mmd_ratio_calc: purely combinational add plus clamp, with outputs ratio and clamp. The counter, sample and output registers stay in the top module.

Test Plan:
1. WIDTH_N=8, ORDER=3, n_int=10, mash_in=0 -> div_pulse every 10 cycles; div_out 5 high / 5 low; ratio_cur=10; clamp_flag=0.
2. n_int=9, mash_in=0 -> period 9; div_out 5 high / 4 low.
3. n_int=10; drive mash_in +3, -4, +1, each applied one cycle after successive strobes -> the following periods measure 13, 6, 11 cycles; ratio_cur matches each.
4. Clamp cases:
   - n_int=5, mash_in=-4 -> ratio 4, clamp_flag=1.
   - n_int=254, mash_in=+3 -> ratio 255, clamp_flag=1.
   - n_int=100, mash_in=-1 -> ratio 99, clamp_flag=0.
5. Assert rst mid-period with count=6 -> all outputs at reset values immediately without a clock; after deassert with n_int=10, the first div_pulse is on the 4th edge (N_MIN=4), then periods of 10.
6. With n_int=8, drop en for 5 cycles mid-period -> count, div_out and ratio_cur frozen; no div_pulse; that period measures 8 enabled cycles, i.e. 13 wall-clock cycles.

Source files
------------

// File: rtl/frac_div_pkg.sv
// Shared defaults for the fractional-N divider: ratio width, MASH order,
// minimum legal ratio and the headroom used for the signed ratio sum.
package frac_div_pkg;

    localparam int WIDTH_N_DEF = 8;
    localparam int ORDER_DEF   = 3;
    localparam int N_MIN_DEF   = 4;

    // Two extra bits hold both the sign and the carry of n_int + mash_in.
    localparam int SEXT_EXTRA  = 2;
    localparam int SEXT_W      = WIDTH_N_DEF + SEXT_EXTRA;

endpackage

// File: rtl/mmd_divider_ctrl_if.sv
// Signal bundle between the MASH/control side (master) and the divider (slave).
interface mmd_divider_ctrl_if
    import frac_div_pkg::*;
#(
    parameter int WIDTH_N = WIDTH_N_DEF,
    parameter int ORDER   = ORDER_DEF
);

    // No valid/ready: n_int and mash_in are level inputs sampled once per
    // period (count==1 with en high); mash_strobe tells the master to move on.
    logic               en;
    logic [WIDTH_N-1:0] n_int;
    logic [ORDER-1:0]   mash_in;
    logic               div_out;
    logic               div_pulse;
    logic               mash_strobe;
    logic [WIDTH_N-1:0] ratio_cur;
    logic               clamp_flag;

    modport master (
        output en, n_int, mash_in,
        input  div_out, div_pulse, mash_strobe, ratio_cur, clamp_flag
    );

    modport slave (
        input  en, n_int, mash_in,
        output div_out, div_pulse, mash_strobe, ratio_cur, clamp_flag
    );

endinterface

// File: rtl/mmd_ratio_calc.sv
// Combinational ratio = n_int + sext(mash_in), clamped to [N_MIN, 2^WIDTH_N-1].
module mmd_ratio_calc
    import frac_div_pkg::*;
#(
    parameter int WIDTH_N = WIDTH_N_DEF,
    parameter int ORDER   = ORDER_DEF,
    parameter int N_MIN   = N_MIN_DEF
) (
    input  logic [WIDTH_N-1:0] n_int_i,
    input  logic [ORDER-1:0]   mash_i,
    output logic [WIDTH_N-1:0] ratio_o,
    output logic               clamp_o
);

    localparam int CW = WIDTH_N + SEXT_EXTRA;

    localparam logic signed [CW-1:0] R_MIN = CW'(N_MIN);
    localparam logic signed [CW-1:0] R_MAX = signed'({{SEXT_EXTRA{1'b0}}, {WIDTH_N{1'b1}}});

    logic signed [CW-1:0] n_ext;
    logic signed [CW-1:0] m_ext;
    logic signed [CW-1:0] r_calc;

    assign n_ext  = signed'({{SEXT_EXTRA{1'b0}}, n_int_i});
    assign m_ext  = signed'({{(CW-ORDER){mash_i[ORDER-1]}}, mash_i});
    assign r_calc = n_ext + m_ext;

    always_comb begin
        ratio_o = r_calc[WIDTH_N-1:0];
        clamp_o = 1'b0;
        if (r_calc < R_MIN) begin
            ratio_o = R_MIN[WIDTH_N-1:0];
            clamp_o = 1'b1;
        end else if (r_calc > R_MAX) begin
            ratio_o = R_MAX[WIDTH_N-1:0];
            clamp_o = 1'b1;
        end
    end

endmodule

// File: rtl/mmd_divider_ctrl.sv
// Multi-modulus divider: down-counts each period, samples the next ratio at
// count==1 and emits a one-cycle strobe plus a ~50% duty divided clock.
module mmd_divider_ctrl
    import frac_div_pkg::*;
#(
    parameter int WIDTH_N = WIDTH_N_DEF,
    parameter int ORDER   = ORDER_DEF,
    parameter int N_MIN   = N_MIN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mmd_divider_ctrl_if.slave bus
);

    localparam logic [WIDTH_N-1:0] ONE       = WIDTH_N'(1);
    localparam logic [WIDTH_N-1:0] CNT_RST   = WIDTH_N'(N_MIN - 1);
    localparam logic [WIDTH_N-1:0] RATIO_RST = WIDTH_N'(N_MIN);

    logic [WIDTH_N-1:0] count_q, count_d;
    logic [WIDTH_N-1:0] ratio_cur_q, ratio_cur_d;
    logic [WIDTH_N-1:0] ratio_pend_q, ratio_pend_d;
    logic               clamp_flag_q, clamp_flag_d;
    logic               clamp_pend_q, clamp_pend_d;
    logic               div_out_q, div_out_d;
    logic               div_pulse_q, div_pulse_d;

    logic [WIDTH_N-1:0] calc_ratio;
    logic               calc_clamp;

    mmd_ratio_calc #(
        .WIDTH_N (WIDTH_N),
        .ORDER   (ORDER),
        .N_MIN   (N_MIN)
    ) u_ratio_calc (
        .n_int_i (bus.n_int),
        .mash_i  (bus.mash_in),
        .ratio_o (calc_ratio),
        .clamp_o (calc_clamp)
    );

    always_comb begin
        count_d      = count_q;
        ratio_cur_d  = ratio_cur_q;
        ratio_pend_d = ratio_pend_q;
        clamp_flag_d = clamp_flag_q;
        clamp_pend_d = clamp_pend_q;
        div_out_d    = div_out_q;
        div_pulse_d  = 1'b0;
        if (bus.en) begin
            if (count_q == '0) begin
                count_d      = ratio_pend_q - ONE;
                ratio_cur_d  = ratio_pend_q;
                clamp_flag_d = clamp_pend_q;
                div_pulse_d  = 1'b1;
            end else begin
                count_d = count_q - ONE;
            end
            if (count_q == ONE) begin
                ratio_pend_d = calc_ratio;
                clamp_pend_d = calc_clamp;
            end
            // Compare against the next-state values so div_out rises with div_pulse.
            div_out_d = (count_d >= (ratio_cur_d >> 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= CNT_RST;
            ratio_cur_q  <= RATIO_RST;
            ratio_pend_q <= RATIO_RST;
            clamp_flag_q <= 1'b0;
            clamp_pend_q <= 1'b0;
            div_out_q    <= 1'b0;
            div_pulse_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            ratio_cur_q  <= ratio_cur_d;
            ratio_pend_q <= ratio_pend_d;
            clamp_flag_q <= clamp_flag_d;
            clamp_pend_q <= clamp_pend_d;
            div_out_q    <= div_out_d;
            div_pulse_q  <= div_pulse_d;
        end
    end

    assign bus.div_out     = div_out_q;
    assign bus.div_pulse   = div_pulse_q;
    assign bus.mash_strobe = div_pulse_q;
    assign bus.ratio_cur   = ratio_cur_q;
    assign bus.clamp_flag  = clamp_flag_q;

endmodule

// File: tb/tb_mmd_divider_ctrl.sv
// Directed bench for mmd_divider_ctrl: period lengths, duty, MASH offsets,
// clamping, asynchronous reset and enable freeze.
module tb_mmd_divider_ctrl;

    localparam int W   = 8;
    localparam int ORD = 3;
    localparam int NMN = 4;
    localparam int BUDGET = 600;

    logic clk;
    logic rst;

    int vectors    = 0;
    int miscompares = 0;

    mmd_divider_ctrl_if #(.WIDTH_N(W), .ORDER(ORD)) bus ();

    mmd_divider_ctrl #(
        .WIDTH_N (W),
        .ORDER   (ORD),
        .N_MIN   (NMN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance negedge by negedge until div_pulse is seen; returns edges passed.
    task automatic wait_pulse(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.div_pulse && cycles < BUDGET);
    endtask

    // Called at the negedge where div_pulse is seen; measures that period.
    task automatic measure(output int len, output int high);
        len  = 0;
        high = 0;
        do begin
            high += int'(bus.div_out);
            @(negedge clk);
            len++;
        end while (!bus.div_pulse && len < BUDGET);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.n_int   = 8'd10;
        bus.mash_in = 3'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.div_out !== 1'b0 || bus.div_pulse !== 1'b0 || bus.mash_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs: got out=%b pulse=%b strobe=%b, want 0 0 0",
                     bus.div_out, bus.div_pulse, bus.mash_strobe);
        end
        vectors++;
        if (bus.ratio_cur !== 8'd4 || bus.clamp_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ratio: got ratio=%0d clamp=%b, want 4 0", bus.ratio_cur, bus.clamp_flag);
        end
        rst    = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic test_startup();
        int c;
        wait_pulse(c);
        vectors++;
        if (c !== NMN) begin
            miscompares++;
            $display("FAIL startup_len: got %0d edges, want %0d", c, NMN);
        end
        vectors++;
        if (bus.ratio_cur !== 8'd10 || bus.mash_strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL startup_ratio: got ratio=%0d strobe=%b, want 10 1", bus.ratio_cur, bus.mash_strobe);
        end
    endtask

    task automatic test_period10();
        int l, h;
        vectors++;
        if (bus.clamp_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL p10_clamp: got %b, want 0", bus.clamp_flag);
        end
        measure(l, h);
        vectors++;
        if (l !== 10 || h !== 5) begin
            miscompares++;
            $display("FAIL p10: got len=%0d high=%0d, want 10 5", l, h);
        end
    endtask

    task automatic test_period9();
        int l, h;
        bus.n_int = 8'd9;
        measure(l, h);
        vectors++;
        if (bus.ratio_cur !== 8'd9) begin
            miscompares++;
            $display("FAIL p9_ratio: got %0d, want 9", bus.ratio_cur);
        end
        measure(l, h);
        vectors++;
        if (l !== 9 || h !== 5) begin
            miscompares++;
            $display("FAIL p9: got len=%0d high=%0d, want 9 5", l, h);
        end
    endtask

    task automatic test_mash();
        logic [2:0] m_seq [3] = '{3'b011, 3'b100, 3'b001};
        int         exp_l [3] = '{13, 6, 11};
        int c, l, h;
        bus.n_int   = 8'd10;
        bus.mash_in = m_seq[0];
        wait_pulse(c);
        for (int i = 0; i < 3; i++) begin
            bus.mash_in = (i < 2) ? m_seq[i+1] : 3'b000;
            vectors++;
            if (bus.ratio_cur !== 8'(exp_l[i])) begin
                miscompares++;
                $display("FAIL mash_ratio[%0d]: got %0d, want %0d", i, bus.ratio_cur, exp_l[i]);
            end
            measure(l, h);
            vectors++;
            if (l !== exp_l[i] || h !== (exp_l[i] + 1) / 2) begin
                miscompares++;
                $display("FAIL mash_len[%0d]: got len=%0d high=%0d, want %0d %0d",
                         i, l, h, exp_l[i], (exp_l[i] + 1) / 2);
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] n_tab [3] = '{8'd5, 8'd254, 8'd100};
        logic [2:0] m_tab [3] = '{3'b100, 3'b011, 3'b111};
        int         r_tab [3] = '{4, 255, 99};
        logic       c_tab [3] = '{1'b1, 1'b1, 1'b0};
        int c, l, h;
        for (int i = 0; i < 3; i++) begin
            bus.n_int   = n_tab[i];
            bus.mash_in = m_tab[i];
            wait_pulse(c);
            vectors++;
            if (bus.ratio_cur !== 8'(r_tab[i]) || bus.clamp_flag !== c_tab[i]) begin
                miscompares++;
                $display("FAIL clamp[%0d]: got ratio=%0d clamp=%b, want %0d %b",
                         i, bus.ratio_cur, bus.clamp_flag, r_tab[i], c_tab[i]);
            end
            measure(l, h);
            vectors++;
            if (l !== r_tab[i] || h !== (r_tab[i] + 1) / 2) begin
                miscompares++;
                $display("FAIL clamp_len[%0d]: got len=%0d high=%0d, want %0d %0d",
                         i, l, h, r_tab[i], (r_tab[i] + 1) / 2);
            end
        end
        bus.n_int   = 8'd10;
        bus.mash_in = 3'b000;
    endtask

    task automatic test_async_reset();
        int c, l, h;
        wait_pulse(c);
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.div_out !== 1'b1 || bus.ratio_cur !== 8'd10) begin
            miscompares++;
            $display("FAIL pre_reset: got out=%b ratio=%0d, want 1 10", bus.div_out, bus.ratio_cur);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.div_out !== 1'b0 || bus.div_pulse !== 1'b0 || bus.ratio_cur !== 8'd4 ||
            bus.clamp_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got out=%b pulse=%b ratio=%0d clamp=%b, want 0 0 4 0",
                     bus.div_out, bus.div_pulse, bus.ratio_cur, bus.clamp_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_pulse(c);
        vectors++;
        if (c !== NMN || bus.ratio_cur !== 8'd10) begin
            miscompares++;
            $display("FAIL reset_restart: got edges=%0d ratio=%0d, want %0d 10", c, bus.ratio_cur, NMN);
        end
        measure(l, h);
        vectors++;
        if (l !== 10 || h !== 5) begin
            miscompares++;
            $display("FAIL reset_p10: got len=%0d high=%0d, want 10 5", l, h);
        end
    endtask

    task automatic test_enable();
        int c, len;
        logic d0;
        bus.n_int = 8'd8;
        wait_pulse(c);
        vectors++;
        if (bus.ratio_cur !== 8'd8) begin
            miscompares++;
            $display("FAIL en_ratio: got %0d, want 8", bus.ratio_cur);
        end
        len = 0;
        repeat (2) begin
            @(negedge clk);
            len++;
        end
        d0 = bus.div_out;
        vectors++;
        if (d0 !== 1'b1) begin
            miscompares++;
            $display("FAIL en_pre: got div_out=%b, want 1", d0);
        end
        bus.en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            len++;
            vectors++;
            if (bus.div_pulse !== 1'b0 || bus.mash_strobe !== 1'b0 || bus.div_out !== d0 ||
                bus.ratio_cur !== 8'd8) begin
                miscompares++;
                $display("FAIL en_freeze: got pulse=%b strobe=%b out=%b ratio=%0d, want 0 0 %b 8",
                         bus.div_pulse, bus.mash_strobe, bus.div_out, bus.ratio_cur, d0);
            end
        end
        bus.en = 1'b1;
        do begin
            @(negedge clk);
            len++;
        end while (!bus.div_pulse && len < BUDGET);
        vectors++;
        if (len !== 13) begin
            miscompares++;
            $display("FAIL en_len: got %0d wall cycles, want 13", len);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_period10();
        test_period9();
        test_mash();
        test_clamp();
        test_async_reset();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
